// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern transmitter and its consumers.
package pattern_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_GUARD, TX_DATA, TX_DONE} tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Larger of two elaboration-time integers, used to size shared counters.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: marks the last clk cycle of every BIT_DIV-cycle bit period
// while run is high; the count is held at zero whenever run is low.
module bit_timer #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int DIV_W = $clog2(BIT_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  // Next count and end-of-bit tick.
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick      = 1'b0;
    if (!run) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = {DIV_W{1'b0}};
      tick      = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= {DIV_W{1'b0}};
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter: accepts a word on valid/ready, sends
// GUARD_BITS idle-high bits and then the word MSB-first, each bit held BIT_DIV
// cycles, followed by a single-cycle done pulse. All outputs are registered.
module serial_pattern_tx
  import pattern_pkg::*;
#(
  parameter int PATTERN_W  = 3,
  parameter int GUARD_BITS = 2,
  parameter int BIT_DIV    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PATTERN_W-1:0] in_pattern,
  output logic                 a_out,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(max2(PATTERN_W, GUARD_BITS) + 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_BITS > 0) ? (GUARD_BITS - 1) : 0);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(PATTERN_W - 1);

  tx_state_t            state_q,   state_d;
  logic [PATTERN_W-1:0] shreg_q,   shreg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 a_out_q,   a_out_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  logic run_s;
  logic tick_s;
  logic accept_s;

  // in_ready_q mirrors state_q == TX_IDLE, so accepting never sees in_valid combinationally at the output.
  assign accept_s = in_valid && in_ready_q;

  // The bit timer only runs while bits are actually on the line.
  always_comb begin
    run_s = 1'b0;
    case (state_q)
      TX_GUARD: run_s = 1'b1;
      TX_DATA:  run_s = 1'b1;
      default:  run_s = 1'b0;
    endcase
  end

  bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .run  (run_s),
    .tick (tick_s)
  );

  // Next state, shift register and bit counter; bit_cnt restarts on every state change.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      TX_IDLE: begin
        if (accept_s) begin
          shreg_d   = in_pattern;
          bit_cnt_d = {CNT_W{1'b0}};
          state_d   = (GUARD_BITS > 0) ? TX_GUARD : TX_DATA;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_GUARD: begin
        if (tick_s && (bit_cnt_q == GUARD_LAST)) begin
          state_d   = TX_DATA;
          bit_cnt_d = {CNT_W{1'b0}};
        end else if (tick_s) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      TX_DATA: begin
        if (tick_s && (bit_cnt_q == DATA_LAST)) begin
          shreg_d   = shreg_q << 1;
          state_d   = TX_DONE;
          bit_cnt_d = {CNT_W{1'b0}};
        end else if (tick_s) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          shreg_d = shreg_q;
        end
      end
      TX_DONE: begin
        state_d   = TX_IDLE;
        bit_cnt_d = {CNT_W{1'b0}};
      end
      default: begin
        state_d   = TX_IDLE;
        bit_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output values for the coming cycle, decoded from next state so the registered outputs line up with state_q.
  always_comb begin
    a_out_d    = LINE_IDLE;
    in_ready_d = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    case (state_d)
      TX_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      TX_GUARD: a_out_d = LINE_IDLE;
      TX_DATA:  a_out_d = shreg_d[PATTERN_W-1];
      TX_DONE:  done_d  = 1'b1;
      default: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      shreg_q    <= {PATTERN_W{1'b0}};
      bit_cnt_q  <= {CNT_W{1'b0}};
      a_out_q    <= LINE_IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      a_out_q    <= a_out_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign a_out    = a_out_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench: two transmitter configurations checked every cycle
// against a timeline model of a transfer, plus directed scenarios.
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v0, r0, a0, b0, d0;
  logic [2:0] p0;
  logic       v1, r1, a1, b1, d1;
  logic [3:0] p1;

  // Config 0: defaults. Config 1: PATTERN_W=4, GUARD_BITS=0, BIT_DIV=3.
  localparam int P0 = 3, G0 = 2, D0 = 1;
  localparam int P1 = 4, G1 = 0, D1 = 3;
  localparam int L0 = (G0 + P0) * D0 + 1;
  localparam int L1 = (G1 + P1) * D1 + 1;

  serial_pattern_tx #(.PATTERN_W(P0), .GUARD_BITS(G0), .BIT_DIV(D0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(r0), .in_pattern(p0),
    .a_out(a0), .busy(b0), .done(d0));

  serial_pattern_tx #(.PATTERN_W(P1), .GUARD_BITS(G1), .BIT_DIV(D1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_pattern(p1),
    .a_out(a1), .busy(b1), .done(d1));

  int errors = 0;
  int checks = 0;

  // Model: position within the current transfer timeline (-1 = idle) and latched word.
  int         pos0 = -1, pos1 = -1;
  logic [3:0] lat0 = 4'd0, lat1 = 4'd0;
  int         done0_n = 0, done1_n = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_line(input int pos, input logic [3:0] pat,
                                    input int p, input int g, input int d);
    if (pos < 0) return 1'b1;
    if (pos < g * d) return 1'b1;
    if (pos < (g + p) * d) return pat[p - 1 - (pos - g * d) / d];
    return 1'b1;
  endfunction

  function automatic int next_pos(input int pos, input int len, input logic rst, input logic v);
    if (rst) return -1;
    if (pos >= 0) return (pos + 1 >= len) ? -1 : pos + 1;
    if (v) return 0;
    return -1;
  endfunction

  // One clock: update model at the edge, compare every output mid-cycle.
  task automatic cycle();
    @(posedge clk);
    if (!reset && pos0 < 0 && v0) lat0 = {1'b0, p0};
    if (!reset && pos1 < 0 && v1) lat1 = p1;
    pos0 = next_pos(pos0, L0, reset, v0);
    pos1 = next_pos(pos1, L1, reset, v1);
    @(negedge clk);
    check_val("u0_a_out",    a0, exp_line(pos0, lat0, P0, G0, D0));
    check_val("u0_in_ready", r0, pos0 < 0);
    check_val("u0_busy",     b0, pos0 >= 0);
    check_val("u0_done",     d0, pos0 == L0 - 1);
    check_val("u1_a_out",    a1, exp_line(pos1, lat1, P1, G1, D1));
    check_val("u1_in_ready", r1, pos1 < 0);
    check_val("u1_busy",     b1, pos1 >= 0);
    check_val("u1_done",     d1, pos1 == L1 - 1);
    if (d0) done0_n++;
    if (d1) done1_n++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && !(r0 && r1); i++) cycle();
    check_val("idle_reached", {r0, r1}, 2'b11);
  endtask

  logic [4:0]  line5;
  logic [2:0]  line3;
  logic [11:0] line12;
  int          busy_n, n0, first_d, second_d;
  logic        hist [0:63];

  initial begin
    // Reset held with in_valid high: nothing may start.
    reset = 1'b1; v0 = 1'b1; v1 = 1'b1; p0 = 3'b111; p1 = 4'hF;
    repeat (3) begin
      cycle();
      check_val("rst_a_out", a0, 1'b1);
      check_val("rst_ready", r0, 1'b1);
      check_val("rst_done",  d0, 1'b0);
    end
    v0 = 1'b0; v1 = 1'b0; reset = 1'b0;
    cycle();
    check_val("rst_no_start", {b0, b1}, 2'b00);

    // Default config, 3'b001.
    p0 = 3'b001; v0 = 1'b1;
    cycle();
    v0 = 1'b0; p0 = 3'b000;
    line5[4] = a0;
    for (int i = 3; i >= 0; i--) begin cycle(); line5[i] = a0; end
    check_val("dflt_line", line5, 5'b11001);
    cycle(); check_val("dflt_done",  d0, 1'b1);
    cycle(); check_val("dflt_ready", r0, 1'b1);

    // Config 1, 4'b1010 with each bit held 3 cycles.
    p1 = 4'b1010; v1 = 1'b1;
    cycle();
    v1 = 1'b0; p1 = 4'b0000;
    line12[11] = a1; busy_n = int'(b1);
    for (int i = 10; i >= 0; i--) begin cycle(); line12[i] = a1; busy_n += int'(b1); end
    check_val("div_line", line12, 12'b111000111000);
    cycle(); check_val("div_done", d1, 1'b1); busy_n += int'(b1);
    cycle(); busy_n += int'(b1);
    check_val("div_busy_len", busy_n, 13);
    check_val("div_ready", r1, 1'b1);

    // Offer during DATA is ignored.
    n0 = done0_n;
    p0 = 3'b001; v0 = 1'b1;
    cycle();
    v0 = 1'b0;
    cycle(); cycle();
    line3[2] = a0; v0 = 1'b1; p0 = 3'b111;
    cycle();
    line3[1] = a0;
    check_val("rej_ready", r0, 1'b0);
    cycle();
    line3[0] = a0; v0 = 1'b0;
    check_val("rej_line", line3, 3'b001);
    wait_idle();
    cycle();
    check_val("rej_done_cnt", done0_n - n0, 1);

    // Reset in the second DATA cycle aborts the transfer.
    n0 = done0_n;
    p0 = 3'b001; v0 = 1'b1;
    cycle();
    v0 = 1'b0;
    cycle(); cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_val("abort_a_out", a0, 1'b1);
    check_val("abort_ready", r0, 1'b1);
    repeat (6) cycle();
    check_val("abort_no_done", done0_n - n0, 0);
    p0 = 3'b110; v0 = 1'b1;
    cycle();
    v0 = 1'b0;
    line5[4] = a0;
    for (int i = 3; i >= 0; i--) begin cycle(); line5[i] = a0; end
    check_val("abort_next_line", line5, 5'b11110);
    wait_idle();

    // Back-to-back with in_valid held high.
    first_d = -1; second_d = -1;
    p0 = 3'b001; v0 = 1'b1;
    cycle();
    p0 = 3'b100;
    for (int i = 0; i < 40; i++) begin
      hist[i] = a0;
      if (d0 && first_d < 0) first_d = i;
      else if (d0 && second_d < 0) second_d = i;
      if (second_d >= 0) break;
      cycle();
    end
    v0 = 1'b0;
    check_val("b2b_gap", second_d - first_d, 7);
    line5 = 5'b00000;
    if (first_d >= 0 && first_d + 6 < 40) begin
      for (int j = 0; j < 5; j++) line5[4 - j] = hist[first_d + 2 + j];
    end
    check_val("b2b_idle_level", (first_d >= 0) ? hist[first_d + 1] : 1'b0, 1'b1);
    check_val("b2b_second_line", line5, 5'b11100);
    wait_idle();

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      p0 = 3'($urandom);
      p1 = 4'($urandom);
      cycle();
    end
    reset = 1'b0; v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
